// File: rtl/s08_timer.sv
// s08_timer: prescaled 16-bit up-counter with modulo wrap, compare flag
// and level irq, mapped into an 8-byte window on the MiniS08 bus.
module s08_timer #(
  parameter logic [15:0] RESET_MOD = 16'h0000,
  parameter logic [15:0] RESET_CMP = 16'hFFFF
) (
  input  logic       clk50,
  input  logic       Reset,
  input  logic [7:0] dbusin,
  output logic [7:0] tmrout,
  input  logic       sel,
  input  logic [2:0] addr,
  input  logic       Read,
  input  logic       Write,
  output logic       irq
);

  logic        rd, wr, rd_q, wr_q;
  logic        wr_edge, rd_rise, rd_fall;
  logic        tof, toie, run, cf, cie;
  logic [2:0]  ps;
  logic [7:0]  pre, pmask;
  logic [15:0] cnt, cnt_nx, mod, cmp;
  logic [7:0]  modh_buf, cmph_buf, cntl_lat;
  logic        lat_v;
  logic        tick, wrap, cnt_wr, sc_wr;
  logic        tof_set, cf_set;

  assign rd      = Read & sel;
  assign wr      = Write & sel;
  assign wr_edge = wr & ~wr_q;
  assign rd_rise = rd & ~rd_q;
  assign rd_fall = ~rd & rd_q;

  assign pmask = ~(8'hFF << ps);
  assign tick  = run & ((pre & pmask) == pmask);

  // A count above MOD still wraps at the top of the 16-bit range.
  assign wrap   = ((mod != 16'h0000) & (cnt == mod))
                | (cnt == 16'hFFFF);
  assign cnt_nx = wrap ? 16'h0000 : cnt + 16'h0001;

  assign cnt_wr  = wr_edge & ((addr == 3'd1) | (addr == 3'd2));
  assign sc_wr   = wr_edge & (addr == 3'd0);
  assign tof_set = tick & wrap & ~cnt_wr;
  assign cf_set  = tick & (cnt_nx == cmp) & ~cnt_wr;

  always_ff @(posedge clk50) begin
    if (Reset) begin
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      lat_v    <= 1'b0;
      cntl_lat <= 8'h00;
    end else begin
      rd_q <= rd;
      wr_q <= wr;
      if (rd_rise & (addr == 3'd1)) begin
        cntl_lat <= cnt[7:0];
        lat_v    <= 1'b1;
      end else if (rd_fall & (addr == 3'd2)) begin
        lat_v <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (Reset) begin
      cnt <= 16'h0000;
      pre <= 8'h00;
      tof <= 1'b0;
      cf  <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (cnt_wr) begin
        cnt <= 16'h0000;
        pre <= 8'h00;
      end else begin
        if (run) pre <= pre + 8'h01;
        if (tick) cnt <= cnt_nx;
      end
      // Hardware set wins over a same-cycle write-1-to-clear.
      if (tof_set) tof <= 1'b1;
      else if (sc_wr & dbusin[7]) tof <= 1'b0;
      if (cf_set) cf <= 1'b1;
      else if (sc_wr & dbusin[4]) cf <= 1'b0;
      irq <= (tof & toie) | (cf & cie);
    end
  end

  always_ff @(posedge clk50) begin
    if (Reset) begin
      toie     <= 1'b0;
      run      <= 1'b0;
      cie      <= 1'b0;
      ps       <= 3'd0;
      mod      <= RESET_MOD;
      cmp      <= RESET_CMP;
      modh_buf <= 8'h00;
      cmph_buf <= 8'h00;
    end else if (wr_edge) begin
      unique case (addr)
        3'd0: begin
          toie <= dbusin[6];
          run  <= dbusin[5];
          cie  <= dbusin[3];
          ps   <= dbusin[2:0];
        end
        3'd3: modh_buf <= dbusin;
        3'd4: mod      <= {modh_buf, dbusin};
        3'd5: cmph_buf <= dbusin;
        3'd6: cmp      <= {cmph_buf, dbusin};
        default: ;
      endcase
    end
  end

  always_comb begin
    tmrout = 8'h00;
    unique case (addr)
      3'd0: tmrout = {tof, toie, run, cf, cie, ps};
      3'd1: tmrout = cnt[15:8];
      3'd2: tmrout = lat_v ? cntl_lat : cnt[7:0];
      3'd3: tmrout = mod[15:8];
      3'd4: tmrout = mod[7:0];
      3'd5: tmrout = cmp[15:8];
      3'd6: tmrout = cmp[7:0];
      default: tmrout = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_s08_timer.sv
// tb_s08_timer: directed plan steps plus random bus traffic, checked
// against an integer model of the timer rules.
module tb_s08_timer;

  logic       clk50 = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] dbusin = 8'h00;
  logic       sel = 1'b0;
  logic [2:0] addr = 3'd0;
  logic       Read = 1'b0;
  logic       Write = 1'b0;
  logic [7:0] tmrout;
  logic       irq;

  int checks = 0;
  int errors = 0;

  s08_timer dut (
    .clk50  (clk50),
    .Reset  (Reset),
    .dbusin (dbusin),
    .tmrout (tmrout),
    .sel    (sel),
    .addr   (addr),
    .Read   (Read),
    .Write  (Write),
    .irq    (irq)
  );

  always #5 clk50 = ~clk50;

  int m_cnt, m_pre, m_mod, m_cmp, m_mhb, m_chb, m_lat, m_ps;
  bit m_latv, m_tof, m_toie, m_run, m_cf, m_cie, m_irq, m_rdq, m_wrq;

  task automatic model_step();
    bit r, w, we, tk, cw, stof, scf, ntof, ncf, nirq;
    int top, ncnt, npre, a, per;
    logic [7:0] d;
    if (Reset) begin
      m_cnt = 0; m_pre = 0; m_mod = 0; m_cmp = 65535;
      m_mhb = 0; m_chb = 0; m_lat = 0; m_ps = 0;
      m_latv = 0; m_tof = 0; m_toie = 0; m_run = 0;
      m_cf = 0; m_cie = 0; m_irq = 0; m_rdq = 0; m_wrq = 0;
      return;
    end
    r = Read && sel;
    w = Write && sel;
    we = w && !m_wrq;
    a = int'(addr);
    d = dbusin;
    per = 1 << m_ps;
    tk = m_run && ((m_pre % per) == per - 1);
    cw = we && (a == 1 || a == 2);
    nirq = (m_tof && m_toie) || (m_cf && m_cie);
    stof = 0;
    scf = 0;
    ncnt = m_cnt;
    if (tk) begin
      top = (m_mod == 0) ? 65535 : m_mod;
      if (m_cnt == top || m_cnt == 65535) begin
        ncnt = 0;
        stof = 1;
      end else ncnt = m_cnt + 1;
      scf = (ncnt == m_cmp);
    end
    npre = m_run ? (m_pre + 1) % 256 : m_pre;
    if (cw) begin
      ncnt = 0; npre = 0; stof = 0; scf = 0;
    end
    ntof = m_tof;
    ncf = m_cf;
    if (we && a == 0) begin
      if (d[7]) ntof = 0;
      if (d[4]) ncf = 0;
      m_toie = d[6]; m_run = d[5]; m_cie = d[3];
      m_ps = int'(d[2:0]);
    end
    if (stof) ntof = 1;
    if (scf) ncf = 1;
    if (we && a == 3) m_mhb = int'(d);
    if (we && a == 4) m_mod = m_mhb * 256 + int'(d);
    if (we && a == 5) m_chb = int'(d);
    if (we && a == 6) m_cmp = m_chb * 256 + int'(d);
    if (r && !m_rdq && a == 1) begin
      m_lat = m_cnt % 256;
      m_latv = 1;
    end else if (!r && m_rdq && a == 2) m_latv = 0;
    m_rdq = r; m_wrq = w;
    m_cnt = ncnt; m_pre = npre;
    m_tof = ntof; m_cf = ncf; m_irq = nirq;
  endtask

  always @(posedge clk50) model_step();

  function automatic logic [7:0] mread(input logic [2:0] a);
    case (a)
      3'd0: return {m_tof, m_toie, m_run, m_cf, m_cie, 3'(m_ps)};
      3'd1: return 8'(m_cnt / 256);
      3'd2: return m_latv ? 8'(m_lat) : 8'(m_cnt % 256);
      3'd3: return 8'(m_mod / 256);
      3'd4: return 8'(m_mod % 256);
      3'd5: return 8'(m_cmp / 256);
      3'd6: return 8'(m_cmp % 256);
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    check({tag, "_data"}, 16'(tmrout), 16'(mread(addr)));
    check({tag, "_irq"}, 16'(irq), 16'(m_irq));
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d,
                    input int n);
    @(negedge clk50);
    sel = 1'b1; addr = a; dbusin = d; Write = 1'b1;
    repeat (n) begin
      @(negedge clk50);
      #1 chk_all("wr");
    end
    Write = 1'b0; sel = 1'b0;
  endtask

  // Single-cycle write issued at the current negedge.
  task automatic wr1(input logic [2:0] a, input logic [7:0] d);
    sel = 1'b1; addr = a; dbusin = d; Write = 1'b1;
    @(negedge clk50);
    #1 chk_all("wr1");
    Write = 1'b0; sel = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] v);
    @(negedge clk50);
    sel = 1'b1; addr = a; Read = 1'b1;
    @(negedge clk50);
    #1 v = tmrout;
    chk_all("rd");
    @(negedge clk50);
    Read = 1'b0; sel = 1'b0;
  endtask

  logic [7:0] v;
  logic [7:0] rst_exp [8] = '{8'h00, 8'h00, 8'h00, 8'h00,
                              8'h00, 8'hFF, 8'hFF, 8'h00};
  int snap;
  bit ok;

  initial begin
    repeat (3) @(negedge clk50);
    Reset = 1'b0;
    #1 check("rst_irq", 16'(irq), 16'h0);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), v);
      check("rst_read", 16'(v), 16'(rst_exp[i]));
    end

    // Free run at PS=0, then stop and confirm the count freezes.
    wr(3'd0, 8'h20, 2);
    repeat (8) @(negedge clk50);
    rd(3'd1, v);
    check("cnth_10", 16'(v), 16'h00);
    rd(3'd2, v);
    check("cntl_10", 16'(v >= 8'd9 && v <= 8'd11), 16'h1);
    wr(3'd0, 8'h00, 2);
    snap = m_cnt;
    repeat (100) @(negedge clk50);
    rd(3'd1, v);
    rd(3'd2, v);
    check("frozen", 16'(v), 16'(snap % 256));

    // Modulo 5 wrap with TOF and irq.
    wr(3'd2, 8'h00, 2);
    wr(3'd3, 8'h00, 2);
    wr(3'd4, 8'h05, 2);
    wr(3'd0, 8'h60, 2);
    addr = 3'd2;
    for (int i = 0; i < 8; i++) begin
      #1 check("mod_seq", 16'(tmrout), 16'((i + 1) % 6));
      chk_all("mod");
      if (i == 5) check("irq_lag", 16'(irq), 16'h0);
      if (i == 6) check("irq_tof", 16'(irq), 16'h1);
      @(negedge clk50);
    end
    @(negedge clk50);
    sel = 1'b1; addr = 3'd0; dbusin = 8'hE0; Write = 1'b1;
    @(negedge clk50);
    #1 check("tof_w1c", 16'(tmrout[7]), 16'h0);
    check("run_kept", 16'(tmrout[5]), 16'h1);
    Write = 1'b0; sel = 1'b0;
    @(negedge clk50);
    #1 check("irq_w1c", 16'(irq), 16'h0);
    chk_all("w1c");

    // Prescale by 8 and a 40-cycle held counter write.
    wr(3'd3, 8'h00, 2);
    wr(3'd4, 8'h00, 2);
    wr(3'd0, 8'hA3, 2);
    repeat (20) begin
      @(negedge clk50);
      #1 chk_all("ps3");
    end
    @(negedge clk50);
    sel = 1'b1; addr = 3'd2; dbusin = 8'h55; Write = 1'b1;
    repeat (40) @(negedge clk50);
    #1 check("hold40", 16'(tmrout), 16'h4);
    chk_all("hold");
    Write = 1'b0; sel = 1'b0;

    // Coherent 16-bit read around 12FF.
    wr(3'd0, 8'h00, 2);
    wr(3'd2, 8'h00, 2);
    wr(3'd0, 8'h20, 2);
    for (int k = 0; k < 6000 && m_cnt != 16'h12F0; k++)
      @(negedge clk50);
    check("wait_12f0", 16'(m_cnt == 16'h12F0), 16'h1);
    wr(3'd0, 8'h23, 2);
    for (int k = 0; k < 400 && !(m_cnt == 16'h12FF && m_pre % 8 == 0); k++)
      @(negedge clk50);
    check("wait_12ff", 16'(m_cnt == 16'h12FF), 16'h1);
    rd(3'd1, v);
    check("lat_cnth", 16'(v), 16'h12);
    for (int k = 0; k < 100 && m_cnt != 16'h1302; k++)
      @(negedge clk50);
    check("wait_1302", 16'(m_cnt == 16'h1302), 16'h1);
    rd(3'd2, v);
    check("lat_cntl", 16'(v), 16'hFF);
    rd(3'd2, v);
    check("live_cntl", 16'(v), 16'h02);

    // Compare flag, irq and W1C colliding with a hardware set.
    wr(3'd0, 8'h00, 2);
    wr(3'd4, 8'h05, 2);
    wr(3'd2, 8'h00, 2);
    wr(3'd5, 8'h00, 2);
    wr(3'd6, 8'h03, 2);
    wr(3'd0, 8'h28, 2);
    addr = 3'd0;
    for (int k = 0; k < 50 && m_cnt != 3; k++) @(negedge clk50);
    #1 check("cf_set", 16'(tmrout[4]), 16'h1);
    check("cf_irq_lag", 16'(irq), 16'h0);
    @(negedge clk50);
    #1 check("cf_irq", 16'(irq), 16'h1);
    for (int k = 0; k < 50 && m_cnt != 0; k++) @(negedge clk50);
    wr1(3'd0, 8'h38);
    check("cf_w1c", 16'(tmrout[4]), 16'h0);
    for (int k = 0; k < 50 && m_cnt != 2; k++) @(negedge clk50);
    #1 check("cf_irq_off", 16'(irq), 16'h0);
    @(negedge clk50);
    for (int k = 0; k < 50 && m_cnt != 2; k++) @(negedge clk50);
    wr1(3'd0, 8'h38);
    check("cf_collide", 16'(tmrout[4]), 16'h1);

    // Random traffic against the model.
    for (int it = 0; it < 500; it++) begin
      int op;
      logic [2:0] a;
      logic [7:0] d;
      op = $urandom_range(0, 19);
      a = 3'($urandom_range(0, 7));
      d = 8'($urandom);
      if (a == 3'd3 || a == 3'd5) d = 8'h00;
      if (a == 3'd0) d = (d & 8'hFB) | 8'h20;
      if (op < 6) begin
        wr(a, d, $urandom_range(1, 3));
      end else if (op < 12) begin
        rd(a, v);
      end else if (op < 19) begin
        @(negedge clk50);
        addr = a;
        #1 chk_all("idle");
      end else begin
        @(negedge clk50);
        sel = 1'b1; addr = a; dbusin = d; Write = 1'b1;
        Reset = 1'b1;
        @(negedge clk50);
        Reset = 1'b0;
        @(negedge clk50);
        #1 chk_all("rst_wr");
        Write = 1'b0; sel = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
